// File: rtl/controle_pkg.sv
// rtl/controle_pkg.sv - state, opcode, function and ULA codes for the multi-cycle control unit
package controle_pkg;

   localparam logic [2:0] S_INICIO  = 3'd0;
   localparam logic [2:0] S_BUSCA   = 3'd1;
   localparam logic [2:0] S_DECOD   = 3'd2;
   localparam logic [2:0] S_EXEC    = 3'd3;
   localparam logic [2:0] S_MEM     = 3'd4;
   localparam logic [2:0] S_ESCRITA = 3'd5;
   localparam logic [2:0] S_PARADO  = 3'd6;
   localparam logic [2:0] S_ERRO    = 3'd7;

   localparam logic [2:0] OP_LOAD     = 3'b000;
   localparam logic [2:0] OP_SLT      = 3'b001;
   localparam logic [2:0] OP_ADD      = 3'b010;
   localparam logic [2:0] OP_ADDI     = 3'b011;
   localparam logic [2:0] OP_SETZ     = 3'b100;
   localparam logic [2:0] OP_STORE    = 3'b101;
   localparam logic [2:0] OP_BEQZ     = 3'b110;
   localparam logic [2:0] OP_ESPECIAL = 3'b111;

   localparam logic [1:0] FN_HALT = 2'b00;
   localparam logic [1:0] FN_INVS = 2'b01;
   localparam logic [1:0] FN_INVT = 2'b10;
   localparam logic [1:0] FN_JR   = 2'b11;

   localparam logic [1:0] ULA_ADD  = 2'b00;
   localparam logic [1:0] ULA_SLT  = 2'b01;
   localparam logic [1:0] ULA_SETZ = 2'b10;

   localparam logic [1:0] FONTE_IMM = 2'b00;
   localparam logic [1:0] FONTE_REG = 2'b01;
   localparam logic [1:0] FONTE_SLT = 2'b10;

   typedef struct packed {
      logic       escrev_mem;
      logic       ler_mem;
      logic       jump;
      logic       halt;
      logic       escrev_reg;
      logic       beqz;
      logic [1:0] ula_op;
      logic [1:0] fonte_ula;
      logic       escrev_ir;
      logic       escrev_pc;
   } strobes_t;

   localparam int STROBE_W = $bits(strobes_t);

endpackage

// File: rtl/controle_decod.sv
// rtl/controle_decod.sv - Moore strobe decode from state and latched opcode/function
module controle_decod
   import controle_pkg::*;
(
   input  logic [2:0]          estado,
   input  logic [2:0]          op,
   input  logic [1:0]          func,
   output logic [STROBE_W-1:0] strobes
);

   strobes_t s;

   always_comb begin
      s = '0;
      case (estado)
         S_BUSCA: begin
            s.escrev_ir = 1'b1;
            s.escrev_pc = 1'b1;
         end
         S_EXEC: begin
            case (op)
               OP_LOAD, OP_STORE, OP_ADDI: begin
                  s.ula_op    = ULA_ADD;
                  s.fonte_ula = FONTE_IMM;
               end
               OP_ADD:  s.fonte_ula = FONTE_REG;
               OP_SETZ: s.ula_op = ULA_SETZ;
               OP_SLT: begin
                  s.ula_op    = ULA_SLT;
                  s.fonte_ula = FONTE_SLT;
               end
               OP_BEQZ:     s.beqz = 1'b1;
               OP_ESPECIAL: s.jump = (func == FN_JR);
               default: ;
            endcase
         end
         S_MEM: begin
            s.ler_mem    = (op == OP_LOAD);
            s.escrev_mem = (op == OP_STORE);
         end
         S_ESCRITA: s.escrev_reg = 1'b1;
         S_PARADO, S_ERRO: s.halt = 1'b1;
         default: ;
      endcase
   end

   assign strobes = s;

endmodule

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multi-cycle control FSM with memory timeout, halt/resume and retire counter
module controle_multiciclo
   import controle_pkg::*;
#(
   parameter int OPCODE_W    = 3,
   parameter int FUNC_W      = 2,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] OPcode,
   input  logic [FUNC_W-1:0]   BitVerificao,
   input  logic                mem_pronta,
   input  logic                continuar,
   output logic                EscrevMem,
   output logic                LerMem,
   output logic                Jump,
   output logic                Halt,
   output logic                EscrevReg,
   output logic                Beqz,
   output logic [1:0]          UlaOp,
   output logic [1:0]          FonteUla,
   output logic                EscrevIR,
   output logic                EscrevPC,
   output logic                erro,
   output logic [2:0]          estado,
   output logic [CNT_W-1:0]    instr_count
);

   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   logic [2:0]        estado_q, nxt;
   logic [2:0]        op_q;
   logic [1:0]        func_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic              erro_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              retire;
   logic              ilegal;
   strobes_t          s;

   // Only the low three opcode bits name an instruction; anything above them is illegal.
   generate
      if (OPCODE_W > 3) begin : g_ilegal
         assign ilegal = |OPcode[OPCODE_W-1:3];
      end else begin : g_legal
         assign ilegal = 1'b0;
      end
      if (FUNC_W > 2) begin : g_func_alto
         logic unused_func;
         assign unused_func = ^BitVerificao[FUNC_W-1:2];
      end
   endgenerate

   always_comb begin
      nxt    = estado_q;
      retire = 1'b0;
      case (estado_q)
         S_INICIO:  nxt = S_BUSCA;
         S_BUSCA:   nxt = S_DECOD;
         S_DECOD:   nxt = ilegal ? S_ERRO : S_EXEC;
         S_EXEC: begin
            case (op_q)
               OP_LOAD, OP_STORE: nxt = S_MEM;
               OP_BEQZ: begin
                  nxt    = S_BUSCA;
                  retire = 1'b1;
               end
               OP_ESPECIAL: begin
                  if (func_q == FN_HALT) begin
                     nxt    = S_PARADO;
                     retire = 1'b1;
                  end else if (func_q == FN_JR) begin
                     nxt    = S_BUSCA;
                     retire = 1'b1;
                  end else begin
                     nxt = S_ESCRITA;
                  end
               end
               default: nxt = S_ESCRITA;
            endcase
         end
         S_MEM: begin
            if (mem_pronta) begin
               if (op_q == OP_LOAD) begin
                  nxt = S_ESCRITA;
               end else begin
                  nxt    = S_BUSCA;
                  retire = 1'b1;
               end
            end else if (wait_cnt == WAIT_MAX) begin
               nxt = S_ERRO;
            end
         end
         S_ESCRITA: begin
            nxt    = S_BUSCA;
            retire = 1'b1;
         end
         S_PARADO: if (continuar) nxt = S_BUSCA;
         S_ERRO:    nxt = S_ERRO;
         default:   nxt = S_INICIO;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= S_INICIO;
         op_q     <= '0;
         func_q   <= '0;
         wait_cnt <= '0;
         erro_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         estado_q <= nxt;
         if (estado_q == S_DECOD) begin
            op_q   <= OPcode[2:0];
            func_q <= BitVerificao[1:0];
         end
         // Wait counter is zero on every entry into MEM.
         wait_cnt <= (estado_q == S_MEM && nxt == S_MEM) ? wait_cnt + 1'b1 : '0;
         if (nxt == S_ERRO) erro_q <= 1'b1;
         if (retire && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
      end
   end

   controle_decod u_decod (
      .estado  (estado_q),
      .op      (op_q),
      .func    (func_q),
      .strobes (s)
   );

   assign EscrevMem   = s.escrev_mem;
   assign LerMem      = s.ler_mem;
   assign Jump        = s.jump;
   assign Halt        = s.halt;
   assign EscrevReg   = s.escrev_reg;
   assign Beqz        = s.beqz;
   assign UlaOp       = s.ula_op;
   assign FonteUla    = s.fonte_ula;
   assign EscrevIR    = s.escrev_ir;
   assign EscrevPC    = s.escrev_pc;
   assign erro        = erro_q;
   assign estado      = estado_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb/tb_controle_multiciclo.sv - directed and randomized instruction sequences against a per-instruction cycle model
module tb_controle_multiciclo;

   localparam int TIMEOUT = 15;
   localparam int CW      = 4;

   localparam logic [12:0] B_ERRO = 13'h1000;
   localparam logic [12:0] B_EM   = 13'h0800;
   localparam logic [12:0] B_LM   = 13'h0400;
   localparam logic [12:0] B_J    = 13'h0200;
   localparam logic [12:0] B_H    = 13'h0100;
   localparam logic [12:0] B_ER   = 13'h0080;
   localparam logic [12:0] B_BQ   = 13'h0040;
   localparam logic [12:0] B_IR   = 13'h0002;
   localparam logic [12:0] B_PC   = 13'h0001;

   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_RET = 3, K_HALT = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [3:0]    OPcode = '0;
   logic [2:0]    BitVerificao = '0;
   logic          mem_pronta = 1'b0;
   logic          continuar = 1'b0;
   logic          EscrevMem, LerMem, Jump, Halt, EscrevReg, Beqz, EscrevIR, EscrevPC, erro;
   logic [1:0]    UlaOp, FonteUla;
   logic [2:0]    estado;
   logic [CW-1:0] instr_count;
   logic [12:0]   sig;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   controle_multiciclo #(
      .OPCODE_W(4), .FUNC_W(3), .MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .OPcode(OPcode), .BitVerificao(BitVerificao),
      .mem_pronta(mem_pronta), .continuar(continuar),
      .EscrevMem(EscrevMem), .LerMem(LerMem), .Jump(Jump), .Halt(Halt),
      .EscrevReg(EscrevReg), .Beqz(Beqz), .UlaOp(UlaOp), .FonteUla(FonteUla),
      .EscrevIR(EscrevIR), .EscrevPC(EscrevPC), .erro(erro), .estado(estado),
      .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   assign sig = {erro, EscrevMem, LerMem, Jump, Halt, EscrevReg, Beqz, UlaOp, FonteUla, EscrevIR, EscrevPC};

   function automatic logic [12:0] ula(input logic [1:0] v);
      return {7'b0, v, 4'b0};
   endfunction

   function automatic logic [12:0] fonte(input logic [1:0] v);
      return {9'b0, v, 2'b0};
   endfunction

   task automatic chk(input string tag, input logic [2:0] st, input logic [12:0] s);
      checks++;
      assert (estado === st) else begin
         errors++;
         $error("FAIL %s estado got %0d want %0d", tag, estado, st);
      end
      checks++;
      assert (sig === s) else begin
         errors++;
         $error("FAIL %s strobes got %h want %h", tag, sig, s);
      end
   endtask

   task automatic chk_cnt(input string tag);
      checks++;
      assert (instr_count === CW'(exp_cnt)) else begin
         errors++;
         $error("FAIL %s instr_count got %0d want %0d", tag, instr_count, exp_cnt);
      end
   endtask

   task automatic adv;
      @(negedge clock);
   endtask

   task automatic bump;
      exp_cnt = (exp_cnt == (1 << CW) - 1) ? exp_cnt : exp_cnt + 1;
   endtask

   task automatic do_reset;
      #2 reset_n = 1'b0;
      #1 chk("reset_async", 3'd0, 13'h0);
      exp_cnt = 0;
      chk_cnt("reset_cnt");
      @(negedge clock);
      reset_n = 1'b1;
      chk("inicio", 3'd0, 13'h0);
      adv;
   endtask

   // Entered and left at a negedge with the DUT in BUSCA, unless the instruction ends in ERRO.
   task automatic do_instr(input logic [3:0] op4, input logic [2:0] fn3, input int w, input int hold);
      logic [12:0] ex;
      int kind;
      int lat;
      int want;
      OPcode       = op4;
      BitVerificao = fn3;
      mem_pronta   = 1'($urandom);
      continuar    = 1'($urandom);
      lat = 0;
      chk("busca", 3'd1, B_IR | B_PC);
      adv; lat++;
      chk("decod", 3'd2, 13'h0);
      adv; lat++;
      if (op4[3]) begin
         chk("ilegal", 3'd7, B_H | B_ERRO);
         return;
      end
      ex = '0;
      kind = K_ALU;
      case (op4[2:0])
         3'b000: kind = K_LOAD;
         3'b101: kind = K_STORE;
         3'b010: ex = fonte(2'b01);
         3'b011: ex = '0;
         3'b100: ex = ula(2'b10);
         3'b001: ex = ula(2'b01) | fonte(2'b10);
         3'b110: begin ex = B_BQ; kind = K_RET; end
         default: begin
            if (fn3[1:0] == 2'b00) kind = K_HALT;
            else if (fn3[1:0] == 2'b11) begin ex = B_J; kind = K_RET; end
         end
      endcase
      chk("exec", 3'd3, ex);
      adv; lat++;
      if (kind == K_LOAD || kind == K_STORE) begin
         for (int k = 0; k < TIMEOUT; k++) begin
            mem_pronta = (k == w);
            chk("mem", 3'd4, (kind == K_LOAD) ? B_LM : B_EM);
            adv; lat++;
            if (k == w) break;
         end
         mem_pronta = 1'($urandom);
         if (w >= TIMEOUT) begin
            chk("timeout", 3'd7, B_H | B_ERRO);
            return;
         end
      end
      if (kind == K_ALU || kind == K_LOAD) begin
         chk("escrita", 3'd5, B_ER);
         adv; lat++;
      end
      if (kind == K_HALT) begin
         bump();
         chk_cnt("halt_cnt");
         for (int h = 0; h < hold; h++) begin
            continuar = 1'b0;
            chk("parado", 3'd6, B_H);
            adv;
         end
         continuar = 1'b1;
         chk("parado_fim", 3'd6, B_H);
         adv;
         continuar = 1'($urandom);
      end else begin
         bump();
         case (kind)
            K_LOAD:  want = 5 + w;
            K_STORE: want = 4 + w;
            K_RET:   want = 3;
            default: want = 4;
         endcase
         checks++;
         assert (lat == want) else begin
            errors++;
            $error("FAIL latency op %0d got %0d want %0d", op4, lat, want);
         end
      end
      chk_cnt("retire_cnt");
   endtask

   task automatic erro_fica;
      continuar  = 1'b1;
      mem_pronta = 1'b1;
      for (int i = 0; i < 3; i++) begin
         adv;
         chk("erro_fica", 3'd7, B_H | B_ERRO);
      end
      continuar  = 1'b0;
      mem_pronta = 1'b0;
   endtask

   initial begin
      @(negedge clock);
      do_reset();
      do_instr(4'b0010, 3'b000, 0, 0);
      do_instr(4'b0000, 3'b000, 2, 0);
      do_instr(4'b0101, 3'b000, 14, 0);
      do_instr(4'b0111, 3'b000, 0, 9);
      do_instr(4'b0111, 3'b011, 0, 0);
      do_instr(4'b0110, 3'b000, 0, 0);
      do_instr(4'b0111, 3'b101, 0, 0);
      do_instr(4'b0111, 3'b110, 0, 0);
      do_instr(4'b0101, 3'b000, TIMEOUT, 0);
      erro_fica();
      do_reset();
      // Reset in the middle of a load's memory wait.
      OPcode = 4'b0000;
      chk("rst_busca", 3'd1, B_IR | B_PC); adv;
      chk("rst_decod", 3'd2, 13'h0); adv;
      chk("rst_exec", 3'd3, 13'h0); adv;
      mem_pronta = 1'b0;
      chk("rst_mem", 3'd4, B_LM); adv;
      do_reset();
      do_instr(4'b1011, 3'b000, 0, 0);
      erro_fica();
      do_reset();
      for (int n = 0; n < 40; n++) begin
         do_instr({1'b0, 3'($urandom_range(0, 7))}, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 6), $urandom_range(0, 3));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Parametrised multi-cycle control unit for the 8-bit processor; the successor to the single-cycle combinational decoder.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Holds memory strobes under a ready handshake with a timeout.
- Supports halt/resume and keeps a retired-instruction counter.
- Sits between the instruction register (IR) and the datapath: PC, register file, ULA and data memory.

Parameters:
- OPCODE_W, 3, opcode width (>=3); a nonzero opcode bit above bit 2 is illegal.
- FUNC_W, 2, BitVerificao width (>=2); only bits [1:0] are decoded.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_pronta before fault (>=1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- OPcode  in  OPCODE_W  opcode from IR.
- BitVerificao  in  FUNC_W  function field for opcode 111.
- mem_pronta  in  1  data memory ready/ack.
- continuar  in  1  resume request while halted.
- EscrevMem, LerMem, Jump, Halt, EscrevReg, Beqz  out  1 each  datapath strobes.
- UlaOp  out  2  ULA operation.
- FonteUla  out  2  ULA operand source.
- EscrevIR  out  1  load IR.
- EscrevPC  out  1  PC <= PC+1.
- erro  out  1  sticky fault (timeout or illegal opcode).
- estado  out  3  current state code, for debug.
- instr_count  out  CNT_W  retired instructions, saturating.

Behaviour:
- One clock; reset is asynchronous and active-low on reset_n. Assertion at any time, including mid-memory-access, forces state INICIO, clears erro, instr_count and the opcode latch, and forces all outputs to 0.
- Outputs are a Moore decode of the state and the latched opcode. Any output not listed for a state is 0.
- States and codes: INICIO=0, BUSCA=1, DECOD=2, EXEC=3, MEM=4, ESCRITA=5, PARADO=6, ERRO=7.
- INICIO: one cycle, then BUSCA.
- BUSCA: EscrevIR=1, EscrevPC=1; then DECOD.
- DECOD: latch OPcode and BitVerificao[1:0]; no strobes. Illegal opcode goes to ERRO; otherwise EXEC.
- EXEC, driven by the latched opcode:
  - load 000 / store 101: UlaOp=00, FonteUla=00; go to MEM.
  - add 010: FonteUla=01; go to ESCRITA.
  - addi 011: UlaOp=00, FonteUla=00; go to ESCRITA.
  - setz 100: UlaOp=10; go to ESCRITA.
  - slt 001: UlaOp=01, FonteUla=10; go to ESCRITA.
  - beqz 110: Beqz=1 (EscrevReg=0); retire; go to BUSCA.
  - 111/00 halt: go to PARADO.
  - 111/01 invs and 111/10 invt: go to ESCRITA.
  - 111/11 jr: Jump=1; retire; go to BUSCA.
- MEM:
  - LerMem=1 (load) or EscrevMem=1 (store), held every cycle until mem_pronta=1 is sampled.
  - On ready, load goes to ESCRITA; store retires and goes to BUSCA.
  - A wait counter starts at 0 on entry and increments each cycle without ready.
  - When the counter reaches MEM_TIMEOUT with no ready, go to ERRO.
  - mem_pronta is ignored outside MEM.
- ESCRITA: EscrevReg=1 for one cycle (load keeps LerMem=0); retire; go to BUSCA.
- PARADO:
  - Halt=1. Halt retires on entry (instr_count +1).
  - Stay until continuar=1, then go to BUSCA on the next edge; continuar is ignored in all other states.
- ERRO: Halt=1, erro=1. Leave only by reset.
- instr_count saturates at all-ones and never wraps.
- Latency without memory wait states:
  - ALU ops: 4 cycles.
  - beqz, jr: 3 cycles.
  - load: 5+w cycles; store: 4+w cycles, where w = mem_pronta wait cycles.

Decomposition:
- Package controle_pkg holds:
  - state encoding constants;
  - opcode constants (LOAD, STORE, ADD, ADDI, SETZ, SLT, BEQZ, ESPECIAL);
  - function constants (HALT, INVS, INVT, JR);
  - UlaOp and FonteUla codes.
- Sub-module controle_decod: a pure combinational map from latched opcode, function field and state to the strobe vector. The FSM, timeout counter and instr_count stay in the top module.

Test Plan:
- add (010): reset release then OPcode=010.
  - BUSCA: EscrevIR=EscrevPC=1.
  - EXEC: FonteUla=01.
  - Cycle 4 (ESCRITA): EscrevReg=1; instr_count=1.
- load (000), mem_pronta high on 3rd MEM cycle: LerMem=1 for exactly 3 cycles, then EscrevReg=1 one cycle; total 7 cycles; instr_count increments.
- store (101), mem_pronta never asserted, MEM_TIMEOUT=15: EscrevMem=1 for 15 cycles, then estado=7, erro=1, Halt=1.
  - Stays in ERRO through continuar=1.
  - reset_n low clears erro and estado asynchronously.
- halt (111/00): estado=6, Halt=1, held for 10 cycles; continuar=1 gives BUSCA next cycle with Halt=0.
- jr (111/11) and beqz (110): Jump=1 and Beqz=1 respectively for one EXEC cycle; EscrevReg=0; return to BUSCA.
- reset_n pulsed low mid-MEM of a load: all strobes 0 immediately; after release, INICIO then BUSCA; instr_count=0.
